// File: rtl/event_reporter_pkg.sv
// Shared constants, FSM state type and ring address helper for the event reporter.
package event_reporter_pkg;

  localparam logic [15:0] HDR_WORD = 16'hA5A5;
  localparam logic [7:0]  TRL_TAG  = 8'h5A;
  localparam int unsigned TS_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND_HDR,
    SEND_TSH,
    SEND_TSL,
    SEND_DATA,
    SEND_TRL
  } state_e;

  // base < depth and offset <= depth, so one conditional subtract is a full wrap.
  function automatic int unsigned ring_addr(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned depth);
    int unsigned sum;
    sum = base + offset;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/event_ring.sv
// D x 16 snapshot ring: one write port with wrapping pointer and saturating fill
// count, one combinational read port.
module event_ring
  import event_reporter_pkg::*;
#(
  parameter int unsigned D  = 32,
  parameter int unsigned AW = $clog2(D),
  parameter int unsigned FW = $clog2(D + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [AW-1:0] wptr,
  output logic [FW-1:0] fill
);

  logic [15:0]   mem_q [D];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] fill_q, fill_d;

  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (we) begin
      wptr_d = AW'(ring_addr(32'(wptr_q), 32'd1, D));
      if (fill_q != FW'(D)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[wptr_q] <= wdata;
  end

  assign rd_data = mem_q[rd_addr];
  assign wptr    = wptr_q;
  assign fill    = fill_q;

endmodule

// File: rtl/event_reporter.sv
// Captures a pre/post-trigger snapshot of the sample stream on each new event and
// streams it out as a framed, timestamped record over valid/ready.
module event_reporter
  import event_reporter_pkg::*;
#(
  parameter int unsigned PRE  = 16,
  parameter int unsigned POST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] stream,
  input  logic        eventDetected,
  output logic [15:0] txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic [7:0]  dropCount
);

  localparam int unsigned D  = PRE + POST;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned FW = $clog2(D + 1);
  localparam int unsigned PW = (POST > 1) ? $clog2(POST) : 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     post_q, post_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   cnt_q, cnt_d;
  logic [7:0]        drop_q, drop_d;
  logic [7:0]        rpt_q, rpt_d;
  logic [15:0]       txdata_q, txdata_d;
  logic              txvalid_q, txvalid_d;
  logic              evprev_q, evprev_d;

  logic              rise;
  logic              accept;
  logic              we;
  logic [AW-1:0]     nxt_k;
  logic [AW-1:0]     rd_addr;
  logic [15:0]       rd_data;
  logic [AW-1:0]     wptr;
  logic [FW-1:0]     fill;
  logic              slot_ok;
  logic [15:0]       sample_word;

  event_ring #(
    .D  (D),
    .AW (AW),
    .FW (FW)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .wdata   (stream),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wptr    (wptr),
    .fill    (fill)
  );

  assign rise   = eventDetected && !evprev_q;
  assign accept = txvalid_q && txReady;
  assign we     = (state_q == IDLE) || (state_q == CAPTURE);

  // Read address always targets the word loaded on the next accept, so the
  // output register refills every cycle under back-to-back transfers.
  always_comb begin
    nxt_k       = (state_q == SEND_DATA) ? idx_q + 1'b1 : '0;
    rd_addr     = AW'(ring_addr(32'(wptr), 32'(nxt_k), D));
    slot_ok     = (32'(nxt_k) + 32'(fill)) >= D;
    sample_word = slot_ok ? rd_data : '0;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    post_d    = post_q;
    ts_d      = ts_q;
    rpt_d     = rpt_q;
    txdata_d  = txdata_q;
    txvalid_d = txvalid_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          ts_d  = cnt_q;
          rpt_d = drop_q;
          if (POST == 1) begin
            state_d   = SEND_HDR;
            txvalid_d = 1'b1;
            txdata_d  = HDR_WORD;
          end else begin
            state_d = CAPTURE;
            post_d  = PW'(POST - 1);
          end
        end
      end
      CAPTURE: begin
        if (post_q == PW'(1)) begin
          state_d   = SEND_HDR;
          txvalid_d = 1'b1;
          txdata_d  = HDR_WORD;
        end else begin
          post_d = post_q - 1'b1;
        end
      end
      SEND_HDR: begin
        if (accept) begin
          state_d  = SEND_TSH;
          txdata_d = ts_q[TS_W-1:TS_W-16];
        end
      end
      SEND_TSH: begin
        if (accept) begin
          state_d  = SEND_TSL;
          txdata_d = ts_q[15:0];
        end
      end
      SEND_TSL: begin
        if (accept) begin
          state_d  = SEND_DATA;
          idx_d    = '0;
          txdata_d = sample_word;
        end
      end
      SEND_DATA: begin
        if (accept) begin
          if (idx_q == AW'(D - 1)) begin
            state_d  = SEND_TRL;
            txdata_d = {TRL_TAG, rpt_q};
          end else begin
            idx_d    = idx_q + 1'b1;
            txdata_d = sample_word;
          end
        end
      end
      SEND_TRL: begin
        if (accept) begin
          state_d   = IDLE;
          txvalid_d = 1'b0;
          txdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The trailer reports the count latched at trigger; drops that arrive while the
  // record is in flight survive the clear and are reported by the next record.
  always_comb begin
    drop_d = drop_q;
    if ((state_q == SEND_TRL) && accept) drop_d = drop_q - rpt_q;
    if (rise && (state_q != IDLE) && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
    cnt_d    = cnt_q + 1'b1;
    evprev_d = eventDetected;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      post_q    <= '0;
      ts_q      <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      rpt_q     <= '0;
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
      evprev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      post_q    <= post_d;
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      rpt_q     <= rpt_d;
      txdata_q  <= txdata_d;
      txvalid_q <= txvalid_d;
      evprev_q  <= evprev_d;
    end
  end

  assign txData    = txdata_q;
  assign txValid   = txvalid_q;
  assign busy      = (state_q != IDLE);
  assign dropCount = drop_q;

endmodule

// File: tb/tb_event_reporter.sv
// Directed and randomized bench for event_reporter against a record-level model.
module tb_event_reporter;

  localparam int unsigned PRE  = 4;
  localparam int unsigned POST = 4;
  localparam int unsigned D    = PRE + POST;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] stream = '0;
  logic        eventDetected = 1'b0;
  logic        txReady = 1'b0;
  logic [15:0] txData;
  logic        txValid;
  logic        busy;
  logic [7:0]  dropCount;

  event_reporter #(.PRE(PRE), .POST(POST)) dut (
    .clock         (clock),
    .reset         (reset),
    .stream        (stream),
    .eventDetected (eventDetected),
    .txData        (txData),
    .txValid       (txValid),
    .txReady       (txReady),
    .busy          (busy),
    .dropCount     (dropCount)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Record-level model: a sample history of what has been written, a pending
  // word list built when the record starts, and the drop counter rules.
  int unsigned m_idx;
  bit          m_busy;
  int unsigned m_send_at;
  bit          m_snap;
  bit          m_evprev;
  int          m_drop;
  int          m_rpt;
  logic [31:0] m_ts;
  logic [15:0] m_ring[$];
  logic [15:0] m_words[$];
  logic [15:0] got[$];
  int          first_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_busy = 0; m_send_at = 0; m_snap = 0; m_evprev = 0;
    m_drop = 0; m_rpt = 0; m_ts = '0;
    m_ring.delete();
    m_words.delete();
  endtask

  task automatic tick();
    bit was_busy, exp_valid, rise, trl_done;
    @(negedge clock);
    if (!reset) begin
      model_reset();
      check("rst_valid", 32'(txValid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(dropCount), 32'd0);
      check("rst_data", 32'(txData), 32'd0);
    end else begin
      was_busy  = m_busy;
      exp_valid = m_busy && (m_idx >= m_send_at);
      if (exp_valid && !m_snap) begin
        m_snap = 1;
        m_words.delete();
        m_words.push_back(16'hA5A5);
        m_words.push_back(m_ts[31:16]);
        m_words.push_back(m_ts[15:0]);
        for (int i = m_ring.size(); i < int'(D); i++) m_words.push_back(16'h0000);
        foreach (m_ring[i]) m_words.push_back(m_ring[i]);
        m_words.push_back({8'h5A, 8'(m_rpt)});
      end
      check("valid", 32'(txValid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(m_busy));
      check("drop", 32'(dropCount), 32'(m_drop));
      if (exp_valid) check("data", 32'(txData), 32'(m_words[0]));
      if (txValid && txReady) begin
        got.push_back(txData);
        if (first_valid < 0) first_valid = int'(m_idx);
      end
      trl_done = 0;
      if (exp_valid && txReady) begin
        void'(m_words.pop_front());
        if (m_words.size() == 0) begin
          trl_done = 1; m_busy = 0; m_snap = 0;
        end
      end
      if (!was_busy || (m_idx < m_send_at)) begin
        m_ring.push_back(stream);
        if (m_ring.size() > int'(D)) void'(m_ring.pop_front());
      end
      rise = eventDetected && !m_evprev;
      m_evprev = eventDetected;
      if (trl_done) m_drop = m_drop - m_rpt;
      if (rise) begin
        if (!was_busy) begin
          m_busy = 1; m_ts = m_idx; m_send_at = m_idx + POST; m_rpt = m_drop;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      m_idx++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit ev, input bit rdy, input logic [15:0] s);
    eventDetected = ev;
    txReady = rdy;
    stream = s;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    eventDetected = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    got.delete();
    first_valid = -1;
  endtask

  task automatic check_record(input string tag, input int base, input logic [15:0] exp[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(base + exp.size()));
    foreach (exp[i]) begin
      if (base + i < got.size()) check($sformatf("%s_w%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
    end
  endtask

  logic [15:0] exp_q[$];

  initial begin
    first_valid = -1;
    model_reset();

    // 1: reset held, then free-running stream with no events
    for (int i = 0; i < 5; i++) begin stream = 16'($urandom); tick(); end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) drive(1'b0, 1'($urandom), 16'($urandom));
    check("t1_norecord", 32'(got.size()), 32'd0);

    // 2: rise at index 20, sink always ready; event held high past the trigger
    do_reset();
    for (int i = 0; i < 45; i++) drive(m_idx >= 20 && m_idx <= 30, 1'b1, 16'(16'h0100 + m_idx));
    exp_q = {16'hA5A5, 16'h0000, 16'h0014};
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h0110 + i));
    exp_q.push_back(16'h5A00);
    check_record("t2", 0, exp_q);
    check("t2_first", 32'(first_valid), 32'd24);
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3: same record with a 50% ready sink
    do_reset();
    for (int i = 0; i < 90; i++) drive(m_idx >= 20 && m_idx <= 30, 1'($urandom), 16'(16'h0100 + m_idx));
    check_record("t3", 0, exp_q);

    // 4: early trigger leaves the oldest slots unfilled
    do_reset();
    for (int i = 0; i < 30; i++) drive(m_idx >= 2 && m_idx <= 3, 1'b1, 16'(16'h0100 + m_idx));
    exp_q = {16'hA5A5, 16'h0000, 16'h0002, 16'h0000, 16'h0000};
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(16'h0100 + i));
    exp_q.push_back(16'h5A00);
    check_record("t4", 0, exp_q);

    // 5: drop during first record carried into the second record's trailer
    do_reset();
    for (int i = 0; i < 80; i++) begin
      drive((m_idx >= 20 && m_idx <= 22) || (m_idx >= 28 && m_idx <= 29) ||
            (m_idx >= 50 && m_idx <= 51), 1'b1, 16'(16'h0100 + m_idx));
      if (m_idx == 41) check("t5_drop_mid", 32'(dropCount), 32'd1);
    end
    check("t5_len", 32'(got.size()), 32'd24);
    if (got.size() == 24) begin
      check("t5_trl1", 32'(got[11]), 32'h5A00);
      check("t5_ts2", 32'(got[14]), 32'h0032);
      check("t5_trl2", 32'(got[23]), 32'h5A01);
    end
    check("t5_drop_end", 32'(dropCount), 32'd0);

    // 6: asynchronous reset in the middle of SEND_DATA, then a fresh record
    do_reset();
    for (int i = 0; i < 30; i++) drive(m_idx >= 20 && m_idx <= 21, 1'b1, 16'(16'h0100 + m_idx));
    check("t6_pre_valid", 32'(txValid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(txValid), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    got.delete();
    for (int i = 0; i < 50; i++) drive(m_idx >= 30 && m_idx <= 31, 1'b1, 16'(16'h0100 + m_idx));
    exp_q = {16'hA5A5, 16'h0000, 16'h001E};
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h011A + i));
    exp_q.push_back(16'h5A00);
    check_record("t6", 0, exp_q);

    // 7: random stream, events and backpressure
    do_reset();
    for (int i = 0; i < 1500; i++)
      drive(($urandom % 6 == 0) ? !eventDetected : eventDetected, ($urandom % 4) != 0, 16'($urandom));

    // 8: long stall with a toggling event saturates the drop counter
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 620; i++) drive(!eventDetected, 1'b0, 16'($urandom));
    check("t8_sat", 32'(dropCount), 32'd255);
    for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, 16'($urandom));
    check("t8_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
